// File: rtl/output_event_serializer.sv
// Output event serializer: captures monitor output events into a FIFO and
// drains each event as a header word followed by one word per active output.
module output_event_serializer #(
    parameter int NUM_OUT = 5,
    parameter int DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [63:0]       output_k [NUM_OUT],
    input  logic [NUM_OUT-1:0]       output_k_aktv,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_data,
    output logic                     out_is_header,
    output logic                     out_last,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA
    } state_t;

    state_t state;
    state_t state_next;

    // Event storage: one timestamp, one mask and NUM_OUT values per entry
    logic [47:0]        ts_mem   [DEPTH];
    logic [NUM_OUT-1:0] mask_mem [DEPTH];
    logic [63:0]        val_mem  [DEPTH][NUM_OUT];

    logic [47:0]   ts;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [IW-1:0] cur_idx;

    logic               capture_req;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               drop;
    logic               handshake;
    logic [LW-1:0]      level_next;

    logic [47:0]        head_ts;
    logic [NUM_OUT-1:0] head_mask;
    logic [63:0]        head_val;
    logic [4:0]         hdr_mask;
    logic [63:0]        header_word;

    logic [IW-1:0]      low_idx;
    logic               low_found;
    logic [IW-1:0]      next_idx;
    logic               has_next;

    assign capture_req = en && (|output_k_aktv) && !rst;
    assign fifo_full   = (fifo_level == LW'(DEPTH));
    assign handshake   = out_valid && out_ready;
    assign pop         = (state == DATA) && handshake && !has_next;
    // A full FIFO still accepts a capture when the head leaves on the same edge
    assign push        = capture_req && (!fifo_full || pop);
    assign drop        = capture_req && fifo_full && !pop;
    assign level_next  = fifo_level + LW'(push) - LW'(pop);

    assign head_ts   = ts_mem[rd_ptr];
    assign head_mask = mask_mem[rd_ptr];
    assign head_val  = val_mem[rd_ptr][cur_idx];

    // Write the captured event into the slot at the write pointer
    always_ff @(posedge clk) begin
        if (push) begin
            ts_mem[wr_ptr]   <= ts;
            mask_mem[wr_ptr] <= output_k_aktv;
            for (int k = 0; k < NUM_OUT; k++) begin
                val_mem[wr_ptr][k] <= output_k[k];
            end
        end
    end

    // Timestamp, FIFO pointers/level and drop accounting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts         <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (en) begin
                ts <= ts + 48'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_level <= level_next;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

    // Find the lowest set mask bit and the next set bit above the current index
    always_comb begin
        low_idx   = '0;
        low_found = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (head_mask[i] && !low_found) begin
                low_idx   = IW'(i);
                low_found = 1'b1;
            end
        end
        next_idx = '0;
        has_next = 1'b0;
        for (int i = NUM_OUT - 1; i >= 0; i--) begin
            if (head_mask[i] && (IW'(i) > cur_idx)) begin
                next_idx = IW'(i);
                has_next = 1'b1;
            end
        end
    end

    // Build the header word with the mask zero-extended into a 5-bit field
    always_comb begin
        hdr_mask = '0;
        for (int i = 0; i < NUM_OUT && i < 5; i++) begin
            hdr_mask[i] = head_mask[i];
        end
        header_word = {1'b1, 10'b0, hdr_mask, head_ts};
    end

    // Track which output value of the head entry is being sent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_idx <= '0;
        end else if (state == HEADER && handshake) begin
            cur_idx <= low_idx;
        end else if (state == DATA && handshake && has_next) begin
            cur_idx <= next_idx;
        end
    end

    // Serializer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Serializer next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (fifo_level != '0) begin
                    state_next = HEADER;
                end
            end
            HEADER: begin
                if (handshake) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (handshake && !has_next) begin
                    state_next = (level_next != '0) ? HEADER : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Serializer outputs, derived only from state and the FIFO head
    always_comb begin
        out_valid     = 1'b0;
        out_is_header = 1'b0;
        out_last      = 1'b0;
        out_data      = '0;
        case (state)
            HEADER: begin
                out_valid     = 1'b1;
                out_is_header = 1'b1;
                out_data      = header_word;
            end
            DATA: begin
                out_valid = 1'b1;
                out_last  = !has_next;
                out_data  = head_val;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_output_event_serializer.sv
// Directed testbench for output_event_serializer with NUM_OUT=5, DEPTH=8.
module tb_output_event_serializer;

    localparam int NUM_OUT = 5;
    localparam int DEPTH   = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic signed [63:0] vals [NUM_OUT];
    logic [NUM_OUT-1:0] aktv;
    logic               out_valid;
    logic               out_ready;
    logic [63:0]        out_data;
    logic               out_is_header;
    logic               out_last;
    logic               overflow;
    logic [15:0]        drop_count;
    logic [3:0]         fifo_level;

    int compared   = 0;
    int mismatched = 0;

    logic [47:0] ts_exp;
    logic [47:0] cap_ts;
    logic [47:0] cap_ts2;

    output_event_serializer #(
        .NUM_OUT(NUM_OUT),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .output_k     (vals),
        .output_k_aktv(aktv),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_is_header(out_is_header),
        .out_last     (out_last),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .fifo_level   (fifo_level)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [NUM_OUT-1:0] m, input logic r);
        en        = e;
        aktv      = m;
        out_ready = r;
    endtask

    // One rising edge; the timestamp model follows rst/en as seen at that edge
    task automatic tick();
        @(posedge clk);
        if (rst) ts_exp = '0;
        else if (en) ts_exp = ts_exp + 48'd1;
        #1;
    endtask

    function automatic logic [63:0] hdr(input logic [4:0] m, input logic [47:0] t);
        return {1'b1, 10'b0, m, t};
    endfunction

    task automatic expectWord(input string tag, input logic [63:0] d, input logic h, input logic l);
        checkOutput({tag, " valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, " data"}, out_data, d);
        checkOutput({tag, " is_header"}, 64'(out_is_header), 64'(h));
        checkOutput({tag, " last"}, 64'(out_last), 64'(l));
    endtask

    initial begin
        rst    = 1'b1;
        ts_exp = '0;
        applyStimulus(1'b0, '0, 1'b0);
        for (int k = 0; k < NUM_OUT; k++) vals[k] = '0;
        repeat (2) tick();

        // Reset state
        checkOutput("rst fifo_level", 64'(fifo_level), 64'd0);
        checkOutput("rst out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst out_data", out_data, 64'd0);
        checkOutput("rst is_header", 64'(out_is_header), 64'd0);
        checkOutput("rst last", 64'(out_last), 64'd0);
        checkOutput("rst overflow", 64'(overflow), 64'd0);
        checkOutput("rst drop_count", 64'(drop_count), 64'd0);
        rst = 1'b0;

        // Single event at ts=10, mask 00101
        applyStimulus(1'b1, '0, 1'b1);
        repeat (10) tick();
        vals[0] = 64'sd1;
        vals[2] = -64'sd3;
        applyStimulus(1'b1, 5'b00101, 1'b1);
        tick();
        applyStimulus(1'b1, '0, 1'b1);
        checkOutput("t1 level", 64'(fifo_level), 64'd1);
        checkOutput("t1 idle valid", 64'(out_valid), 64'd0);
        tick();
        expectWord("t1 hdr", 64'h8005_0000_0000_000A, 1'b1, 1'b0);
        tick();
        expectWord("t1 d0", 64'd1, 1'b0, 1'b0);
        tick();
        expectWord("t1 d2", 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b1);
        tick();
        checkOutput("t1 end valid", 64'(out_valid), 64'd0);
        checkOutput("t1 end level", 64'(fifo_level), 64'd0);

        // Stalls of 3 cycles in header and in each data word
        vals[1] = 64'sh11;
        vals[4] = 64'sh44;
        cap_ts  = ts_exp;
        applyStimulus(1'b1, 5'b10010, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            expectWord("t2 hdr stall", hdr(5'b10010, cap_ts), 1'b1, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expectWord("t2 d1 stall", 64'h11, 1'b0, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expectWord("t2 d4 stall", 64'h44, 1'b0, 1'b1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        checkOutput("t2 end valid", 64'(out_valid), 64'd0);

        // DEPTH+3 events with ready low: three drops, then ordered drain
        cap_ts = ts_exp;
        for (int i = 0; i < DEPTH + 3; i++) begin
            vals[0] = 64'(100 + i);
            applyStimulus(1'b1, 5'b00001, 1'b0);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t3 level", 64'(fifo_level), 64'd8);
        checkOutput("t3 drops", 64'(drop_count), 64'd3);
        checkOutput("t3 overflow", 64'(overflow), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            expectWord("t3 hdr", hdr(5'b00001, cap_ts + 48'(i)), 1'b1, 1'b0);
            tick();
            expectWord("t3 data", 64'(100 + i), 1'b0, 1'b1);
            tick();
        end
        checkOutput("t3 end valid", 64'(out_valid), 64'd0);
        checkOutput("t3 end level", 64'(fifo_level), 64'd0);

        // Full FIFO, capture on the same edge as the last-word pop
        cap_ts = ts_exp;
        for (int i = 0; i < DEPTH; i++) begin
            vals[0] = 64'(200 + i);
            applyStimulus(1'b1, 5'b00001, 1'b0);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t4 full level", 64'(fifo_level), 64'd8);
        out_ready = 1'b1;
        tick();
        expectWord("t4 d0", 64'd200, 1'b0, 1'b1);
        vals[0] = 64'sd300;
        cap_ts2 = ts_exp;
        applyStimulus(1'b1, 5'b00001, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("t4 level kept", 64'(fifo_level), 64'd8);
        checkOutput("t4 drops kept", 64'(drop_count), 64'd3);
        for (int i = 1; i < DEPTH; i++) begin
            expectWord("t4 hdr", hdr(5'b00001, cap_ts + 48'(i)), 1'b1, 1'b0);
            tick();
            expectWord("t4 data", 64'(200 + i), 1'b0, 1'b1);
            tick();
        end
        expectWord("t4 new hdr", hdr(5'b00001, cap_ts2), 1'b1, 1'b0);
        tick();
        expectWord("t4 new data", 64'd300, 1'b0, 1'b1);
        tick();
        checkOutput("t4 end valid", 64'(out_valid), 64'd0);

        // en low with aktv asserted: no capture, ts frozen, pending drains
        vals[0] = 64'sd7;
        vals[1] = 64'sd8;
        cap_ts  = ts_exp;
        applyStimulus(1'b1, 5'b00011, 1'b0);
        tick();
        applyStimulus(1'b0, 5'b11111, 1'b0);
        repeat (5) tick();
        checkOutput("t5 level", 64'(fifo_level), 64'd1);
        checkOutput("t5 drops", 64'(drop_count), 64'd3);
        out_ready = 1'b1;
        expectWord("t5 hdr", hdr(5'b00011, cap_ts), 1'b1, 1'b0);
        tick();
        expectWord("t5 d0", 64'd7, 1'b0, 1'b0);
        tick();
        expectWord("t5 d1", 64'd8, 1'b0, 1'b1);
        tick();
        checkOutput("t5 drain valid", 64'(out_valid), 64'd0);
        checkOutput("t5 drain level", 64'(fifo_level), 64'd0);
        vals[0] = 64'sd9;
        applyStimulus(1'b1, 5'b00001, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        tick();
        expectWord("t5 frozen ts hdr", hdr(5'b00001, cap_ts + 48'd1), 1'b1, 1'b0);
        tick();
        expectWord("t5 d9", 64'd9, 1'b0, 1'b1);
        tick();

        // Reset during data word 2 of 4
        for (int k = 0; k < 4; k++) vals[k] = 64'(k + 1);
        applyStimulus(1'b1, 5'b01111, 1'b1);
        tick();
        applyStimulus(1'b1, '0, 1'b1);
        tick();
        expectWord("t6 hdr", hdr(5'b01111, cap_ts + 48'd2), 1'b1, 1'b0);
        tick();
        tick();
        expectWord("t6 d1", 64'd2, 1'b0, 1'b0);
        rst     = 1'b1;
        ts_exp  = '0;
        vals[2] = 64'sd55;
        applyStimulus(1'b1, 5'b00100, 1'b1);
        #1;
        checkOutput("t6 rst valid", 64'(out_valid), 64'd0);
        checkOutput("t6 rst level", 64'(fifo_level), 64'd0);
        checkOutput("t6 rst data", out_data, 64'd0);
        checkOutput("t6 rst drops", 64'(drop_count), 64'd0);
        checkOutput("t6 rst overflow", 64'(overflow), 64'd0);
        tick();
        checkOutput("t6 no capture in rst", 64'(fifo_level), 64'd0);
        rst = 1'b0;
        tick();
        applyStimulus(1'b1, '0, 1'b1);
        checkOutput("t6 post level", 64'(fifo_level), 64'd1);
        tick();
        expectWord("t6 post hdr", 64'h8004_0000_0000_0000, 1'b1, 1'b0);
        tick();
        expectWord("t6 post data", 64'd55, 1'b0, 1'b1);
        tick();
        checkOutput("t6 post valid", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/output_event_serializer.md
OUTPUT_EVENT_SERIALIZER -- requirements
Module: output_event_serializer

Interface
REQ-001 SHALL have parameter NUM_OUT, default 5, number of monitor output streams.
REQ-002 SHALL have parameter DEPTH, default 8, event FIFO entries (power of two).
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  in  1  capture/timestamp enable.
REQ-006 SHALL have port output_k (k=0..NUM_OUT-1)  in  64 signed  monitor output value.
REQ-007 SHALL have port output_k_aktv  in  1  output_k valid this cycle.
REQ-008 SHALL have port out_valid  out  1  stream word valid.
REQ-009 SHALL have port out_ready  in  1  downstream accepts word.
REQ-010 SHALL have port out_data  out  64  stream word.
REQ-011 SHALL have port out_is_header  out  1  current word is a header.
REQ-012 SHALL have port out_last  out  1  last word of current event record.
REQ-013 SHALL have port overflow  out  1  sticky; an event was dropped.
REQ-014 SHALL have port drop_count  out  16  dropped events, saturating at 16'hFFFF.
REQ-015 SHALL have port fifo_level  out  clog2(DEPTH)+1  occupied entries.

Function
REQ-016 SHALL keep a 48-bit timestamp ts counting rising edges with en=1, wrapping from 2^48-1 to 0; frozen while en=0.
REQ-017 SHALL form aktv mask m[k]=output_k_aktv and capture an event at an edge with en=1 and m!=0.
REQ-018 Each entry SHALL hold {ts value before that edge's increment, m, all NUM_OUT values}.
REQ-019 Capture SHALL be accepted if fifo_level<DEPTH or a pop occurs on the same edge; otherwise dropped.
REQ-020 Drop SHALL set overflow and increment drop_count (saturating); FIFO contents unaffected.
REQ-021 Serializer FSM SHALL have states IDLE, HEADER, DATA.
REQ-022 IDLE: out_valid=0; move to HEADER on the edge where fifo_level!=0.
REQ-023 HEADER: out_valid=1, out_is_header=1, out_last=0, out_data={1'b1, 10'b0, m[4:0] zero-extended to bits 52:48, ts[47:0]}; on out_valid&&out_ready go to DATA at lowest set bit of m.
REQ-024 DATA: out_data=value of current index k, out_is_header=0, out_last=1 iff no higher set bit in m.
REQ-025 DATA handshake SHALL advance to the next higher set bit; on the last word pop the entry, go to HEADER if another entry remains after the pop, else IDLE.
REQ-026 out_data, out_is_header, out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 Latency: event captured at edge E SHALL show header on out_valid after edge E+1 when FSM was IDLE and en has no effect on draining.
REQ-028 Record of popcount(m)=p SHALL be exactly p+1 words; with out_ready held 1, p+1 consecutive cycles.
REQ-029 Records SHALL leave in capture order; back-to-back records with no idle cycle between them.
REQ-030 Simultaneous capture and pop at full SHALL leave fifo_level=DEPTH and drop nothing.

Reset
REQ-031 rst=1 SHALL immediately clear: FIFO (fifo_level=0), FSM=IDLE, out_valid=0, out_is_header=0, out_last=0, out_data=0, ts=0, overflow=0, drop_count=0.
REQ-032 Reset mid-record SHALL discard the partial record; first post-reset record starts with a header.
REQ-033 No capture SHALL occur on an edge where rst=1.

Verification
REQ-034 Single event m=5'b00101, output_0=1, output_2=-3, ready=1 at ts=10 -> header data 0x8005_0000_0000_000A (bit 63 set, mask 5), then 1, then -3 with out_last=1.
REQ-035 Ready stalled 3 cycles in HEADER and DATA -> words held stable, no loss, order unchanged.
REQ-036 Ready=0, DEPTH+3 consecutive events -> fifo_level=DEPTH, drop_count=3, overflow=1; release ready -> first DEPTH records emitted in order.
REQ-037 Full FIFO, capture on the same edge as last-word pop -> event kept, drop_count unchanged.
REQ-038 en=0 for 5 cycles with aktv asserted -> no capture, ts unchanged; pending records still drain.
REQ-039 rst asserted during DATA word 2 of 4 -> out_valid low immediately, all counters 0; next event emits full record from header.
